// File: rtl/period_meter_pkg.sv
// Shared types for the oscillator period meter.
package period_meter_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      MEASURE = 1'b1
   } state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer for an asynchronous input plus a registered one-cycle rising-edge strobe.
module sync_edge_detect
   import period_meter_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic CLK,
   input  logic RESET,
   input  logic IN,
   output logic RISE
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   last_q;

   // RISE fires SYNC_STAGES+1 clocks after the raw edge; the extra flop keeps it glitch-free.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         sync_q <= '0;
         last_q <= 1'b0;
         RISE   <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], IN};
         last_q <= sync_q[SYNC_STAGES-1];
         RISE   <= sync_q[SYNC_STAGES-1] & ~last_q;
      end
   end

endmodule

// File: rtl/period_meter.sv
// Sums the period of an asynchronous oscillator over 2^AVG_BITS periods, in CLK cycles,
// and strobes each finished window into the downstream filter chain.
module period_meter
   import period_meter_pkg::*;
#(
   parameter int DATA_BITS   = 28,
   parameter int AVG_BITS    = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic                 EN,
   input  logic                 FREQ_IN,
   output logic [DATA_BITS-1:0] OUT_VALUE,
   output logic                 OUT_CE,
   output logic                 OVERFLOW,
   output logic                 BUSY
);

   localparam logic [DATA_BITS-1:0] MAX_COUNT = {DATA_BITS{1'b1}};
   localparam int                   CNT_BITS  = AVG_BITS + 1;
   localparam logic [CNT_BITS-1:0]  LAST_EDGE = CNT_BITS'((1 << AVG_BITS) - 1);

   state_t                state;
   logic [DATA_BITS-1:0]  acc;
   logic [CNT_BITS-1:0]   edge_cnt;
   logic                  rise;

   sync_edge_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .CLK  (CLK),
      .RESET(RESET),
      .IN   (FREQ_IN),
      .RISE (rise)
   );

   // The closing edge of one window is the opening edge of the next, so acc and
   // edge_cnt restart on that same strobe and no cycle is ever lost between windows.
   // The reported distance is acc+1 because acc reads 0 in the first MEASURE cycle.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= IDLE;
         acc       <= '0;
         edge_cnt  <= '0;
         OUT_VALUE <= '0;
         OUT_CE    <= 1'b0;
         OVERFLOW  <= 1'b0;
      end else begin
         OUT_CE <= 1'b0;
         case (state)
            IDLE: begin
               if (EN && rise) begin
                  acc      <= '0;
                  edge_cnt <= '0;
                  state    <= MEASURE;
               end
            end
            MEASURE: begin
               if (!EN) begin
                  state <= IDLE;
               end else if (acc == MAX_COUNT) begin
                  OUT_VALUE <= MAX_COUNT;
                  OVERFLOW  <= 1'b1;
                  OUT_CE    <= 1'b1;
                  state     <= IDLE;
               end else if (rise && (edge_cnt == LAST_EDGE)) begin
                  OUT_VALUE <= acc + 1'b1;
                  OVERFLOW  <= 1'b0;
                  OUT_CE    <= 1'b1;
                  acc       <= '0;
                  edge_cnt  <= '0;
               end else begin
                  acc <= acc + 1'b1;
                  if (rise) begin
                     edge_cnt <= edge_cnt + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign BUSY = (state == MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Self-checking bench: two period_meter instances share FREQ_IN; expectations come from an
// edge-time model that derives window sums directly from the planned oscillator edges.
module tb_period_meter;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        EN = 1'b0;
   logic        FREQ_IN = 1'b0;

   logic [7:0]  outValueA;
   logic        ceA, ovfA, busyA;
   logic [11:0] outValueB;
   logic        ceB, ovfB, busyB;

   typedef struct {
      int value;
      bit ovf;
   } exp_t;

   exp_t expA[$];
   exp_t expB[$];
   exp_t eA, eB;
   int   edges[$];
   int   plan[$];
   int   lastVal[2];
   bit   lastOvf[2];
   bit   jitterPhase = 1'b0;
   int   sumB = 0;
   int   checks = 0;
   int   errors = 0;

   period_meter #(.DATA_BITS(8), .AVG_BITS(2), .SYNC_STAGES(2)) dutA (
      .CLK(CLK), .RESET(RESET), .EN(EN), .FREQ_IN(FREQ_IN),
      .OUT_VALUE(outValueA), .OUT_CE(ceA), .OVERFLOW(ovfA), .BUSY(busyA)
   );

   period_meter #(.DATA_BITS(12), .AVG_BITS(0), .SYNC_STAGES(3)) dutB (
      .CLK(CLK), .RESET(RESET), .EN(EN), .FREQ_IN(FREQ_IN),
      .OUT_VALUE(outValueB), .OUT_CE(ceB), .OVERFLOW(ovfB), .BUSY(busyB)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic pushExp(input int which, input int value, input bit ovf);
      exp_t e;
      e.value = value;
      e.ovf   = ovf;
      if (which == 0) expA.push_back(e);
      else            expB.push_back(e);
      lastVal[which] = value;
      lastOvf[which] = ovf;
   endtask

   // Windows of n edges measured as edge-time differences; a window longer than maxc saturates,
   // and an edge landing exactly on the saturation cycle is swallowed by it.
   task automatic modelWindows(input int which, input int n, input int maxc, input int endTime);
      int open = -1;
      int cnt = 0;
      int t;
      foreach (edges[k]) begin
         t = edges[k];
         if (open < 0) begin
            open = t;
            cnt  = 0;
         end else if (t - open > maxc) begin
            pushExp(which, maxc, 1'b1);
            if (t - open == maxc + 1) begin
               open = -1;
            end else begin
               open = t;
               cnt  = 0;
            end
         end else begin
            cnt++;
            if (cnt == n) begin
               pushExp(which, t - open, 1'b0);
               open = t;
               cnt  = 0;
            end
         end
      end
      if (open >= 0 && endTime - open > maxc + 10) pushExp(which, maxc, 1'b1);
   endtask

   // Scoreboard: every strobe must match the next modelled window.
   always @(negedge CLK) begin
      if (ceA === 1'b1) begin
         if (expA.size() == 0) begin
            checkOutput("a_unexpected_ce", 1, 0);
         end else begin
            eA = expA.pop_front();
            checkOutput("a_value", outValueA, eA.value);
            checkOutput("a_ovf", ovfA, eA.ovf);
            if (eA.ovf) checkOutput("a_busy_sat", busyA, 0);
         end
      end
      if (ceB === 1'b1) begin
         if (expB.size() == 0) begin
            checkOutput("b_unexpected_ce", 1, 0);
         end else begin
            eB = expB.pop_front();
            checkOutput("b_value", outValueB, eB.value);
            checkOutput("b_ovf", ovfB, eB.ovf);
         end
         if (jitterPhase) begin
            sumB += outValueB;
            checkOutput("b_jitter_range", (outValueB >= 6 && outValueB <= 8), 1);
         end
      end
   end

   // Drives the planned periods with sub-cycle offsets, then optionally aborts with EN=0.
   task automatic applyStimulus(input int tail, input bit abort);
      int t = 0;
      int hi, lo;
      edges.delete();
      foreach (plan[k]) begin
         edges.push_back(t);
         t += plan[k];
      end
      modelWindows(0, 4, 255, t + tail);
      modelWindows(1, 1, 4095, t + tail);
      EN = 1'b1;
      repeat (5) @(negedge CLK);
      foreach (plan[k]) begin
         hi = (plan[k] < 20) ? plan[k] / 2 : 5;
         lo = plan[k] - hi;
         #($urandom_range(0, 3));
         FREQ_IN = 1'b1;
         repeat (hi) @(negedge CLK);
         #($urandom_range(0, 3));
         FREQ_IN = 1'b0;
         repeat (lo) @(negedge CLK);
      end
      repeat (tail) @(negedge CLK);
      if (abort) begin
         #1;
         EN = 1'b0;
         @(negedge CLK);
         checkOutput("a_busy_abort", busyA, 0);
         checkOutput("b_busy_abort", busyB, 0);
         repeat (3) @(negedge CLK);
         checkOutput("a_missing_ce", expA.size(), 0);
         checkOutput("b_missing_ce", expB.size(), 0);
         checkOutput("a_hold_value", outValueA, lastVal[0]);
         checkOutput("a_hold_ovf", ovfA, lastOvf[0]);
         checkOutput("b_hold_value", outValueB, lastVal[1]);
         checkOutput("b_hold_ovf", ovfB, lastOvf[1]);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_a_value"}, outValueA, 0);
      checkOutput({tag, "_a_ce"}, ceA, 0);
      checkOutput({tag, "_a_ovf"}, ovfA, 0);
      checkOutput({tag, "_a_busy"}, busyA, 0);
      checkOutput({tag, "_b_value"}, outValueB, 0);
      checkOutput({tag, "_b_ce"}, ceB, 0);
      checkOutput({tag, "_b_ovf"}, ovfB, 0);
      checkOutput({tag, "_b_busy"}, busyB, 0);
   endtask

   initial begin
      lastVal = '{0, 0};
      lastOvf = '{1'b0, 1'b0};
      repeat (3) @(negedge CLK);
      checkResetState("reset");
      RESET = 1'b1;
      repeat (2) @(negedge CLK);

      $display("[TB] steady period 10");
      plan.delete();
      repeat (13) plan.push_back(10);
      applyStimulus(15, 1'b1);

      $display("[TB] edges while disabled");
      repeat (3) begin
         FREQ_IN = 1'b1;
         repeat (5) @(negedge CLK);
         FREQ_IN = 1'b0;
         repeat (5) @(negedge CLK);
      end
      repeat (10) @(negedge CLK);
      checkOutput("a_idle_ignore", busyA, 0);
      checkOutput("b_idle_ignore", busyB, 0);

      $display("[TB] period change 10 to 13");
      plan.delete();
      repeat (6) plan.push_back(10);
      repeat (9) plan.push_back(13);
      applyStimulus(15, 1'b1);

      $display("[TB] saturation then recovery");
      plan.delete();
      plan.push_back(400);
      repeat (5) plan.push_back(10);
      applyStimulus(15, 1'b1);

      $display("[TB] async reset mid-window");
      plan.delete();
      repeat (6) plan.push_back(10);
      applyStimulus(15, 1'b0);
      #2;
      RESET = 1'b0;
      #1;
      checkResetState("async_reset");
      checkOutput("a_pending_at_reset", expA.size(), 0);
      checkOutput("b_pending_at_reset", expB.size(), 0);
      lastVal = '{0, 0};
      lastOvf = '{1'b0, 1'b0};
      @(negedge CLK);
      RESET = 1'b1;
      plan.delete();
      repeat (9) plan.push_back(10);
      applyStimulus(15, 1'b1);

      $display("[TB] jittered period 7");
      plan.delete();
      repeat (40) plan.push_back($urandom_range(6, 8));
      sumB = 0;
      jitterPhase = 1'b1;
      applyStimulus(15, 1'b1);
      jitterPhase = 1'b0;
      checkOutput("b_jitter_sum", sumB, edges[edges.size()-1] - edges[0]);

      $display("[TB] random periods");
      plan.delete();
      repeat (25) plan.push_back($urandom_range(2, 40));
      applyStimulus(15, 1'b1);

      $display("[TB] saturation boundary");
      plan.delete();
      plan.push_back(64); plan.push_back(64); plan.push_back(64); plan.push_back(63);
      repeat (4) plan.push_back(64);
      repeat (6) plan.push_back(10);
      applyStimulus(15, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period of an asynchronous sensor oscillator signal in CLK cycles, summed over 2^AVG_BITS consecutive periods.
- Produces one DATA_BITS sample per completed window plus a single-cycle strobe.
- Sits upstream of the low-pass filter chain: OUT_VALUE drives the filter IN_VALUE and OUT_CE drives the filter CE, so the filter advances once per new measurement.

Parameters:
- DATA_BITS, 28, width of the cycle accumulator and of OUT_VALUE.
- AVG_BITS, 2, window length = 2^AVG_BITS oscillator periods (range 0..6).
- SYNC_STAGES, 2, synchronizer flop count on FREQ_IN (range 2..3).

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous reset, active-low (0 = reset).
- EN  input  1  measurement enable; 0 aborts and idles.
- FREQ_IN  input  1  asynchronous oscillator signal.
- OUT_VALUE  output  DATA_BITS  cycles counted over the last completed window; held between updates.
- OUT_CE  output  1  one-cycle strobe, asserted in the same cycle OUT_VALUE updates.
- OVERFLOW  output  1  last window saturated; sticky until the next good window.
- BUSY  output  1  1 while in state MEASURE.

Behaviour:
- Reset (RESET=0, asynchronous): OUT_VALUE=0, OUT_CE=0, OVERFLOW=0, BUSY=0, state=IDLE. Synchronizer flops, edge counter and accumulator are cleared.
- Edge detect: FREQ_IN passes through SYNC_STAGES flops. A rising edge produces strobe E, high for 1 CLK, SYNC_STAGES+1 cycles after the edge.
- States:
  - IDLE: BUSY=0. Wait for E with EN=1. On E: accumulator := 0, edge counter := 0, go to MEASURE.
  - MEASURE: accumulator increments by 1 every cycle. Each E increments the edge counter.
  - Window end: on the E that completes the window (edge counter reaches 2^AVG_BITS), in the next cycle OUT_VALUE := strobe-to-strobe distance in CLK cycles, OUT_CE=1 and OVERFLOW := 0.
- Strobe-to-strobe distance:
  - Example: FREQ_IN period 10 CLK, AVG_BITS=2 gives 40.
  - Accumulator and edge counter restart on the same E, so the closing edge of window k is the opening edge of window k+1. There is no dead time.
  - Steady-state OUT_CE spacing equals the window length.
- Saturation:
  - If the accumulator reaches 2^DATA_BITS-1 before the window completes: OUT_VALUE := all ones, OVERFLOW := 1, OUT_CE=1 for one cycle, go to IDLE.
  - The next E restarts measurement from IDLE.
  - If E arrives in the same cycle as saturation, saturation wins.
- EN:
  - EN=0 in MEASURE: go to IDLE next cycle, no OUT_CE. OUT_VALUE and OVERFLOW are held.
  - EN=0 in IDLE: E is ignored.
  - EN rising: the measurement starts at the first E after EN=1.
- E in the first MEASURE cycle: legal. It counts as an edge, giving a distance of 1 per period.
- AVG_BITS=0: every E closes a window; OUT_VALUE is the single-period length.
- OUT_CE is never asserted in IDLE except for the saturation exit cycle.
- Width: the accumulator is exactly DATA_BITS, with no wrap (it saturates). The edge counter is AVG_BITS+1 bits.

Decomposition:
- Shared header/package holds:
  - state encodings (IDLE, MEASURE) as localparams;
  - the helper constant MAX_COUNT = {DATA_BITS{1'b1}}.
- Sub-module sync_edge_detect (parameter SYNC_STAGES; ports CLK, RESET, IN, RISE): synchronizer plus rising-edge strobe, reusable for other sensor inputs.
- Counter and FSM live in period_meter.

Test Plan:
1. Reset release, EN=1, FREQ_IN square period 10 CLK, AVG_BITS=2 -> first OUT_CE about 40 cycles after the first detected edge, OUT_VALUE=40, OVERFLOW=0, then OUT_CE every 40 cycles with value 40.
2. Period changes from 10 to 13 CLK mid-window -> the mixed window reports the exact sum (e.g. 10+10+13+13=46), then 52 steady.
3. DATA_BITS=8, FREQ_IN stuck low after one edge -> after 255 counts OUT_VALUE=255, OVERFLOW=1, one OUT_CE, BUSY=0. The next valid window (period 10) gives 40 and OVERFLOW=0.
4. EN dropped to 0 at cycle 15 of a window -> no OUT_CE, OUT_VALUE keeps the previous 40, BUSY falls the next cycle. Re-enable -> the next window starts at the first edge and reports 40.
5. Asynchronous RESET asserted mid-window between clock edges -> outputs go to 0 immediately (not at the next CLK). After release, no OUT_CE until a full new window completes.
6. AVG_BITS=0, period 7 CLK, FREQ_IN jittered ±1 CLK relative to CLK -> each OUT_VALUE is in {6,7,8}, and consecutive values sum to the elapsed strobe count (no lost cycles).
